wiscsc15_fetch: RTL and testbench
=================================

Name: wiscsc15_fetch

Overview:
- Instruction-fetch stage for the WISC-SC15 single-issue core. Sits directly upstream of the opcode decoder/control unit.
- Owns the PC and drives a request/acknowledge instruction-memory port.
- Presents {instruction, opcode, pc, pc+1} with a valid/stall handshake to decode.
- Accepts redirects from branch/call/ret resolution and stops fetching on HALT (opcode 4'b1111).

Parameters:
- RESET_PC, 16'h0000, PC loaded on reset (word address).
- AW, 16, PC / instruction-memory address width.
- IW, 16, instruction width; opcode = instr[IW-1:IW-4].

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- imem_req  out  1  fetch request, registered.
- imem_addr  out  AW  word address of the request; stable while imem_req high and not acked.
- imem_ack  in  1  rdata valid this cycle; may arrive in the same cycle req first rises.
- imem_rdata  in  IW  instruction word, sampled when imem_req && imem_ack.
- stall  in  1  decode cannot accept the presented instruction.
- redirect  in  1  load a new PC and flush.
- redirect_pc  in  AW  target for redirect.
- if_valid  out  1  if_instr/if_pc are valid.
- if_instr  out  IW  fetched instruction.
- if_opcode  out  4  if_instr[15:12], feeds the control unit Opcode.
- if_pc  out  AW  address of if_instr.
- if_pc_plus1  out  AW  if_pc+1 mod 2^AW, return address for call.
- halted  out  1  fetch stopped on HALT.

Behaviour:
- **Reset (rst_n low, async):**
  - pc=RESET_PC; state=FETCH.
  - imem_req=0, imem_addr=RESET_PC.
  - if_valid=0, if_instr=0, if_pc=0, if_pc_plus1=0, halted=0.
  - Skid buffer empty; drop_pending=0.
  - imem_req rises the first clock after deassertion.
  - Reset mid-transaction abandons it; the memory must tolerate req dropping on reset.
- **States:**
  - FETCH: issue or hold a request.
  - WAIT_DROP: an outstanding request is to be discarded.
  - HALTED.
- **Request rule:**
  - In FETCH, imem_req=1, imem_addr=pc whenever the skid buffer is empty.
  - Once raised, req and addr hold until imem_ack. Abandoning a request is illegal except on reset.
- **Accept on ack** (req && ack, not dropping):
  - pc <= pc+1, wrapping FFFF->0000.
  - Data goes to the output register if it is free or being consumed this cycle (if_valid=0 or stall=0); otherwise it goes to the skid buffer.
  - Skid full ⇒ no new request issued.
- **Output handshake:**
  - Transfer occurs on cycles with if_valid && !stall.
  - While stall=1 the outputs hold stable.
  - On transfer the output reloads from the skid buffer if full, else from an ack this cycle, else if_valid drops to 0.
- **Throughput and latency:**
  - With zero-wait memory (ack every cycle), one instruction per cycle.
  - req in cycle N with ack ⇒ if_valid at N+1.
- **HALT:**
  - A captured instruction with opcode 4'b1111 is delivered normally.
  - The stage enters HALTED, imem_req goes to 0 and halted goes to 1.
  - Only redirect or reset leaves HALTED.
- **Redirect (highest priority, overrides stall and halt):**
  - pc <= redirect_pc; if_valid <= 0; skid cleared; halted <= 0.
  - Any ack in the same cycle is discarded.
  - If a request is outstanding and not acked this cycle, enter WAIT_DROP: keep the old req/addr until ack, discard its data, then return to FETCH with a request at redirect_pc.
  - A second redirect during WAIT_DROP updates pc only; the stage stays in WAIT_DROP.
  - Redirect latency with zero-wait memory: redirect at N ⇒ req at redirect_pc at N+1 ⇒ if_valid at N+2.
- **Simultaneous redirect and stall:** the redirect wins and the output is flushed.
- No X on any output after reset; if_opcode is always if_instr[15:12].

Decomposition:
- Shared package wiscsc15_pkg holds:
  - Opcode constants: OP_ADD..OP_RET, OP_HALT=4'b1111.
  - Widths AW/IW.
  - RESET_PC default.
  - Fetch state enum.
- One sub-module, wiscsc15_fetch_skid: a one-entry {instr, pc} buffer with load, unload and flush.

Test Plan:
- **Zero-wait stream:** reset, ack tied high, mem[i]=16'h0i00+i, stall=0 ⇒ if_pc 0,1,2,3 on consecutive cycles from the 2nd clock after reset; if_opcode=0.
- **Stall with ack:** stall=1 for 3 cycles while if_pc=2 ⇒ outputs frozen; skid captures pc 3; no request for pc 4 until stall drops; then 2,3,4 are delivered with no loss or duplicates.
- **Redirect during wait:** ack delayed 3 cycles on addr 5, redirect to 16'h0040 in the 1st wait cycle ⇒ addr 5 held until ack, its data dropped, next req addr 0x0040, if_pc=0x0040 is the first valid.
- **Redirect plus ack plus stall in one cycle:** redirect_pc=0x0100 ⇒ if_valid=0 next cycle, acked data discarded, next req addr 0x0100.
- **HALT:** mem[7]=16'hF000 ⇒ delivered with if_pc=7, then halted=1 and imem_req=0 for 10 cycles; redirect to 0x0000 ⇒ fetch resumes at 0.
- **Wrap:** RESET_PC=16'hFFFF ⇒ if_pc FFFF with if_pc_plus1 0000, next if_pc 0000.

Source files
------------

// File: rtl/wiscsc15_pkg.sv
// Shared constants and types for the WISC-SC15 front end.
package wiscsc15_pkg;

    localparam int FETCH_AW = 16;
    localparam int FETCH_IW = 16;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_NAND = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_INC  = 4'h4;
    localparam logic [3:0] OP_SRA  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_SLL  = 4'h7;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_LHB  = 4'hA;
    localparam logic [3:0] OP_LLB  = 4'hB;
    localparam logic [3:0] OP_B    = 4'hC;
    localparam logic [3:0] OP_CALL = 4'hD;
    localparam logic [3:0] OP_RET  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_WAIT_DROP = 2'd1,
        ST_HALTED    = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/wiscsc15_fetch_skid.sv
// One-entry {instr, pc} holding buffer used when decode stalls on an acked fetch.
module wiscsc15_fetch_skid
    import wiscsc15_pkg::*;
#(
    parameter int AW = FETCH_AW,
    parameter int IW = FETCH_IW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          unload,
    input  logic          flush,
    input  logic [IW-1:0] d_instr,
    input  logic [AW-1:0] d_pc,
    output logic          full,
    output logic [IW-1:0] q_instr,
    output logic [AW-1:0] q_pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full    <= 1'b0;
            q_instr <= '0;
            q_pc    <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (load) begin
            full    <= 1'b1;
            q_instr <= d_instr;
            q_pc    <= d_pc;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/wiscsc15_fetch.sv
// Instruction fetch: owns the PC, runs the req/ack imem port and hands
// {instr, pc, pc+1} to decode through a valid/stall output register.
module wiscsc15_fetch
    import wiscsc15_pkg::*;
#(
    parameter int AW = FETCH_AW,
    parameter int IW = FETCH_IW,
    parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_rdata,
    input  logic          stall,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          if_valid,
    output logic [IW-1:0] if_instr,
    output logic [3:0]    if_opcode,
    output logic [AW-1:0] if_pc,
    output logic [AW-1:0] if_pc_plus1,
    output logic          halted
);

    localparam logic [AW-1:0] PC_ONE = AW'(1);

    fetch_state_t  state, state_d;
    logic [AW-1:0] pc, pc_d, addr_d;
    logic          req_d, fetching;
    logic          accept, xfer, out_load, is_halt, pending;
    logic          skid_load, skid_unload, skid_full;
    logic [IW-1:0] skid_instr;
    logic [AW-1:0] skid_pc;

    // A request still waiting for its ack cannot be withdrawn.
    assign pending     = imem_req && !imem_ack;
    assign accept      = imem_req && imem_ack && fetching && !redirect;
    assign xfer        = if_valid && !stall;
    assign out_load    = accept && (!if_valid || !stall);
    assign skid_load   = accept && if_valid && stall;
    assign skid_unload = xfer && skid_full && !redirect;
    assign is_halt     = (imem_rdata[IW-1 -: 4] == OP_HALT);
    assign if_opcode   = if_instr[IW-1 -: 4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_FETCH;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (redirect) begin
            state_d = pending ? ST_WAIT_DROP : ST_FETCH;
        end else begin
            case (state)
                ST_FETCH:     if (accept && is_halt) state_d = ST_HALTED;
                ST_WAIT_DROP: if (imem_ack) state_d = ST_FETCH;
                default:      state_d = state;
            endcase
        end
    end

    always_comb begin
        fetching = (state == ST_FETCH);
        halted   = (state == ST_HALTED);
    end

    // Next PC and request; a pending request keeps its address across a redirect.
    always_comb begin
        pc_d   = pc;
        req_d  = imem_req;
        addr_d = imem_addr;
        if (redirect) begin
            pc_d = redirect_pc;
            if (!pending) begin
                req_d  = 1'b1;
                addr_d = redirect_pc;
            end
        end else if (accept) begin
            pc_d   = pc + PC_ONE;
            req_d  = !(is_halt || skid_load);
            addr_d = pc + PC_ONE;
        end else if (fetching && !imem_req && (!skid_full || skid_unload)) begin
            req_d  = 1'b1;
            addr_d = pc;
        end else if (state == ST_WAIT_DROP && imem_ack) begin
            addr_d = pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            pc        <= pc_d;
            imem_req  <= req_d;
            imem_addr <= addr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid    <= 1'b0;
            if_instr    <= '0;
            if_pc       <= '0;
            if_pc_plus1 <= '0;
        end else if (redirect) begin
            if_valid <= 1'b0;
        end else if (skid_unload) begin
            if_valid    <= 1'b1;
            if_instr    <= skid_instr;
            if_pc       <= skid_pc;
            if_pc_plus1 <= skid_pc + PC_ONE;
        end else if (out_load) begin
            if_valid    <= 1'b1;
            if_instr    <= imem_rdata;
            if_pc       <= imem_addr;
            if_pc_plus1 <= imem_addr + PC_ONE;
        end else if (xfer) begin
            if_valid <= 1'b0;
        end
    end

    wiscsc15_fetch_skid #(.AW(AW), .IW(IW)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (skid_load),
        .unload  (skid_unload),
        .flush   (redirect),
        .d_instr (imem_rdata),
        .d_pc    (imem_addr),
        .full    (skid_full),
        .q_instr (skid_instr),
        .q_pc    (skid_pc)
    );

endmodule

// File: tb/tb_wiscsc15_fetch.sv
// Directed bench for wiscsc15_fetch: an in-order PC-stream scoreboard plus literal spot checks.
module tb_wiscsc15_fetch;
    import wiscsc15_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_ack;
    logic [15:0] imem_addr, imem_rdata;
    logic        stall, redirect;
    logic [15:0] redirect_pc;
    logic        if_valid, halted;
    logic [15:0] if_instr, if_pc, if_pc_plus1;
    logic [3:0]  if_opcode;

    logic        w_req, w_ack, w_stall, w_redirect, w_valid, w_halted;
    logic [15:0] w_addr, w_rdata, w_redirect_pc, w_instr, w_pc, w_pc1;
    logic [3:0]  w_op;

    logic plant_halt;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] word(input logic [15:0] a);
        return {4'h0, a[3:0], a[7:0]};
    endfunction

    function automatic logic [15:0] mem_at(input logic [15:0] a, input logic ph);
        return (ph && a == 16'h0007) ? 16'hF000 : word(a);
    endfunction

    assign imem_rdata = mem_at(imem_addr, plant_halt);
    assign w_rdata    = word(w_addr);

    wiscsc15_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_instr(if_instr), .if_opcode(if_opcode),
        .if_pc(if_pc), .if_pc_plus1(if_pc_plus1), .halted(halted)
    );

    wiscsc15_fetch #(.RESET_PC(16'hFFFF)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
        .stall(w_stall), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
        .if_valid(w_valid), .if_instr(w_instr), .if_opcode(w_op),
        .if_pc(w_pc), .if_pc_plus1(w_pc1), .halted(w_halted)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: decode must see consecutive PCs, restarting at each redirect target,
    // with nothing after a delivered HALT until the next redirect.
    logic [15:0] exp_pc, p_pc, p_instr, p_addr;
    logic        exp_halt, p_hold, p_wait, p_redir;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc   = 16'h0000;
            exp_halt = 1'b0;
            p_hold   = 1'b0;
            p_wait   = 1'b0;
            p_redir  = 1'b0;
        end else begin
            chk("opcode_field", 16'(if_opcode), 16'(if_instr[15:12]));
            if (halted)   chk("halted_no_req", 16'(imem_req), 16'd0);
            if (exp_halt) chk("valid_after_halt", 16'(if_valid), 16'd0);
            if (p_redir)  chk("redirect_flush", 16'(if_valid), 16'd0);
            if (p_hold) begin
                chk("stall_hold_valid", 16'(if_valid), 16'd1);
                chk("stall_hold_pc", if_pc, p_pc);
                chk("stall_hold_instr", if_instr, p_instr);
            end
            if (p_wait) begin
                chk("req_held", 16'(imem_req), 16'd1);
                chk("addr_held", imem_addr, p_addr);
            end
            if (if_valid) begin
                chk("instr_data", if_instr, mem_at(if_pc, plant_halt));
                chk("pc_plus1", if_pc_plus1, if_pc + 16'd1);
            end
            if (if_valid && !stall && !exp_halt) begin
                chk("stream_pc", if_pc, exp_pc);
                exp_pc = if_pc + 16'd1;
                if (if_instr[15:12] == OP_HALT) exp_halt = 1'b1;
            end
            if (redirect) begin
                exp_pc   = redirect_pc;
                exp_halt = 1'b0;
            end
            p_redir = redirect;
            p_hold  = if_valid && stall && !redirect;
            p_pc    = if_pc;
            p_instr = if_instr;
            p_wait  = imem_req && !imem_ack;
            p_addr  = imem_addr;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; imem_ack = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
        plant_halt = 1'b0;
        w_ack = 1'b1; w_stall = 1'b0; w_redirect = 1'b0; w_redirect_pc = 16'h0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_req", 16'(imem_req), 16'd0);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_valid", 16'(if_valid), 16'd0);
        chk("rst_instr", if_instr, 16'h0000);
        chk("rst_pc", if_pc, 16'h0000);
        chk("rst_pc1", if_pc_plus1, 16'h0000);
        chk("rst_halted", 16'(halted), 16'd0);
        chk("rst_wrap_addr", w_addr, 16'hFFFF);
        tick(); tick();
        rst_n = 1'b1;

        // zero-wait stream
        tick();
        chk("e1_req", 16'(imem_req), 16'd1);
        chk("e1_addr", imem_addr, 16'h0000);
        chk("e1_valid", 16'(if_valid), 16'd0);
        chk("e1_wrap_req", 16'(w_req), 16'd1);
        tick();
        chk("e2_valid", 16'(if_valid), 16'd1);
        chk("e2_pc", if_pc, 16'h0000);
        chk("e2_instr", if_instr, 16'h0000);
        chk("e2_op", 16'(if_opcode), 16'd0);
        chk("wrap_valid", 16'(w_valid), 16'd1);
        chk("wrap_pc", w_pc, 16'hFFFF);
        chk("wrap_pc1", w_pc1, 16'h0000);
        chk("wrap_op", 16'(w_op), 16'd0);
        tick();
        chk("e3_pc", if_pc, 16'h0001);
        chk("e3_instr", if_instr, 16'h0101);
        chk("wrap_next_pc", w_pc, 16'h0000);
        chk("wrap_next_pc1", w_pc1, 16'h0001);
        chk("wrap_halted", 16'(w_halted), 16'd0);
        tick();
        chk("e4_pc", if_pc, 16'h0002);
        chk("e4_instr", if_instr, 16'h0202);

        // stall with ack: pc 3 goes to the skid, no request for 4 while stalled
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", if_pc, 16'h0002);
            chk("stall_no_req", 16'(imem_req), 16'd0);
        end
        stall = 1'b0;
        tick();
        chk("unstall_pc", if_pc, 16'h0003);
        chk("unstall_req", 16'(imem_req), 16'd1);
        chk("unstall_addr", imem_addr, 16'h0004);
        tick();
        chk("unstall_pc4", if_pc, 16'h0004);
        chk("req5_addr", imem_addr, 16'h0005);

        // redirect while addr 5 waits for its ack
        imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        chk("wd_valid", 16'(if_valid), 16'd0);
        chk("wd_req", 16'(imem_req), 16'd1);
        chk("wd_addr", imem_addr, 16'h0005);
        tick();
        chk("wd_addr2", imem_addr, 16'h0005);
        tick();
        chk("wd_addr3", imem_addr, 16'h0005);
        imem_ack = 1'b1;
        tick();
        chk("wd_dropped", 16'(if_valid), 16'd0);
        chk("wd_new_req", 16'(imem_req), 16'd1);
        chk("wd_new_addr", imem_addr, 16'h0040);
        tick();
        chk("wd_first_valid", 16'(if_valid), 16'd1);
        chk("wd_first_pc", if_pc, 16'h0040);
        chk("wd_first_instr", if_instr, 16'h0040);

        // redirect + ack + stall together
        stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0100;
        tick();
        stall = 1'b0; redirect = 1'b0;
        chk("rsa_valid", 16'(if_valid), 16'd0);
        chk("rsa_req", 16'(imem_req), 16'd1);
        chk("rsa_addr", imem_addr, 16'h0100);
        tick();
        chk("rsa_pc", if_pc, 16'h0100);

        // HALT at address 7
        plant_halt = 1'b1; redirect = 1'b1; redirect_pc = 16'h0004;
        tick();
        redirect = 1'b0;
        chk("h_addr", imem_addr, 16'h0004);
        tick(); tick(); tick();
        chk("h_pc6", if_pc, 16'h0006);
        tick();
        chk("h_pc7", if_pc, 16'h0007);
        chk("h_instr", if_instr, 16'hF000);
        chk("h_op", 16'(if_opcode), 16'hF);
        chk("h_halted", 16'(halted), 16'd1);
        chk("h_req", 16'(imem_req), 16'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("h_stay_halted", 16'(halted), 16'd1);
            chk("h_stay_noreq", 16'(imem_req), 16'd0);
            chk("h_stay_invalid", 16'(if_valid), 16'd0);
        end
        redirect = 1'b1; redirect_pc = 16'h0000;
        tick();
        redirect = 1'b0;
        chk("resume_halted", 16'(halted), 16'd0);
        chk("resume_req", 16'(imem_req), 16'd1);
        chk("resume_addr", imem_addr, 16'h0000);
        tick();
        chk("resume_valid", 16'(if_valid), 16'd1);
        chk("resume_pc0", if_pc, 16'h0000);
        tick();
        chk("resume_pc1", if_pc, 16'h0001);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
